adpll_cfg_bank: RTL and testbench
=================================

// Module: adpll_cfg_bank
// PURPOSE
//  Parametrised, clock-synchronous configuration register bank for the ADPLL core.
//  Pad-level program/commit strobes write a shadow bank; a commit copies every
//  shadow register to the active bank in one cycle, aligned to a loop-safe sync tick.
//  Replaces per-register edge-clocked loading; drives ndiv/alpha/beta/dco_* of the core.
// PARAMETERS
//  DW        5    width of each config register and of pgm_value/rd_data
//  NPARAM    6    number of config registers (0=ndiv,1=alpha,2=beta,3=dco_offset,4=dco_thresh,5=kdco)
//  SELW      3    width of param_sel/rd_sel; 2**SELW >= NPARAM
//  TMO_W     8    commit timeout counter width; timeout = 2**TMO_W-1 clk cycles
// PORTS
//  clk         in   1            system clock
//  clr         in   1            reset, asynchronous, active-high
//  program     in   1            pad strobe; rising edge writes shadow[param_sel]
//  commit      in   1            pad strobe; rising edge arms shadow->active copy
//  param_sel   in   SELW         write target index
//  pgm_value   in   DW           write data
//  sync_tick   in   1            1-cycle pulse in clk domain marking loop-safe update point
//  err_clr     in   1            synchronous clear of sticky error flags
//  rd_sel      in   SELW         readback index (shadow bank)
//  rd_data     out  DW           shadow[rd_sel]; 0 if rd_sel >= NPARAM
//  cfg_active  out  NPARAM*DW    active bank, register i at [i*DW +: DW]
//  cfg_busy    out  1            commit armed, waiting for sync_tick/timeout
//  cfg_done    out  1            1-cycle pulse when commit completes (copy or abort)
//  err_sel     out  1            sticky: write with param_sel >= NPARAM
//  err_busy    out  1            sticky: program edge rejected while cfg_busy
//  par_err     out  1            sticky: commit aborted on parity mismatch (0 when macro off)
// BEHAVIOUR
//  - clr: shadow, active, FSM, counter, sync flops -> 0; all outputs 0 (rd_data 0).
//  - program/commit each pass a 2-FF synchroniser + edge detect; action occurs in the
//    3rd clk after the pad rise. param_sel/pgm_value sampled that cycle; must be stable
//    >=3 clk before and through it. Level held high = one edge only.
//  - FSM IDLE: program edge, param_sel<NPARAM -> shadow[param_sel]<=pgm_value;
//    param_sel>=NPARAM -> no write, err_sel<=1. commit edge -> ARM, counter<=0.
//  - Simultaneous program+commit edge in IDLE: write performed, then ARM; the committed
//    data includes the new write.
//  - ARM: cfg_busy=1; counter increments each clk, saturates. sync_tick=1 or counter
//    reaches 2**TMO_W-1 -> COPY. program edge in ARM: dropped, err_busy<=1.
//    commit edge in ARM: ignored, no flag.
//  - COPY (1 cycle): active[i]<=shadow[i] for all i atomically; cfg_done=1; -> IDLE.
//    Active updates on the clk edge leaving COPY; cfg_busy low in COPY.
//  - sync_tick ignored outside ARM. sync_tick in the same cycle ARM is entered is not used.
//  - err_clr clears err_sel/err_busy/par_err; a new error in the same cycle wins (flag set).
//  - clr mid-ARM: commit abandoned, active returns to 0, no cfg_done.
//  - rd_data combinational from shadow; unaffected by FSM state.
// CONFIGURATION
//  ADPLL_CFG_PARITY_EN defined: each shadow register stores an even-parity bit computed
//    at write; in COPY all parities are rechecked; any mismatch -> no active update,
//    par_err<=1, cfg_done still pulses. Parity bits reset to 0 (consistent with 0 data).
//  Undefined: no parity storage, COPY unconditional, par_err tied 0.
// TESTING
//  1 clr pulse mid-run -> cfg_active=0, rd_data=0, flags 0, cfg_busy=0 asynchronously.
//  2 program sel=1 val=5'h13, rd_sel=1 -> rd_data=5'h13 3 clk after edge; cfg_active unchanged.
//  3 write all 6 regs, commit, sync_tick 10 clk later -> cfg_done 1 clk after tick, all 6 active.
//  4 commit with no sync_tick -> cfg_busy for 255 clk, then copy and cfg_done.
//  5 sel=3'd7 write -> err_sel=1, shadow unchanged; program during ARM -> err_busy=1; err_clr -> 0.
//  6 PARITY_EN: force a shadow bit flip before COPY -> par_err=1, active unchanged, cfg_done=1.

Source files
------------

// File: rtl/adpll_cfg_bank_if.sv
// adpll_cfg_bank_if: pad strobes, write/readback bus and status of the ADPLL
// configuration bank. The pad program strobe is carried on 'prog' because
// 'program' is a reserved word in SystemVerilog.
interface adpll_cfg_bank_if #(
  parameter int DW     = 5,
  parameter int NPARAM = 6,
  parameter int SELW   = 3
);
  logic                 prog;        // pad program strobe, rising edge writes shadow
  logic                 commit;      // pad commit strobe, rising edge arms the copy
  logic [SELW-1:0]      param_sel;   // write target index
  logic [DW-1:0]        pgm_value;   // write data
  logic                 sync_tick;   // loop-safe update point, 1-cycle pulse
  logic                 err_clr;     // clears the sticky error flags
  logic [SELW-1:0]      rd_sel;      // shadow readback index
  logic [DW-1:0]        rd_data;     // shadow[rd_sel], 0 when out of range
  logic [NPARAM*DW-1:0] cfg_active;  // active bank, register i at [i*DW +: DW]
  logic                 cfg_busy;    // commit armed, waiting for tick/timeout
  logic                 cfg_done;    // pulse when a commit completes or aborts
  logic                 err_sel;     // sticky: write to a nonexistent register
  logic                 err_busy;    // sticky: write rejected while armed
  logic                 par_err;     // sticky: commit aborted on parity mismatch

  // Bench / pad side drives the strobes and indices, observes status.
  modport master (
    output prog, commit, param_sel, pgm_value, sync_tick, err_clr, rd_sel,
    input  rd_data, cfg_active, cfg_busy, cfg_done, err_sel, err_busy, par_err
  );

  // Configuration bank side.
  modport slave (
    input  prog, commit, param_sel, pgm_value, sync_tick, err_clr, rd_sel,
    output rd_data, cfg_active, cfg_busy, cfg_done, err_sel, err_busy, par_err
  );
endinterface

// File: rtl/adpll_cfg_bank.sv
// adpll_cfg_bank: clock-synchronous shadow/active configuration bank for the
// ADPLL core (ndiv, alpha, beta, dco_offset, dco_thresh, kdco).
// Pad strobes are synchronised and edge-detected; program edges write the
// shadow bank, a commit edge arms a single-cycle shadow->active copy that
// fires on sync_tick or after a 2**TMO_W-1 cycle timeout.
// Optional feature macro: ADPLL_CFG_PARITY_EN -- stores an even-parity bit per
// shadow register and aborts the copy (setting par_err) on any mismatch.
module adpll_cfg_bank #(
  parameter int DW     = 5,
  parameter int NPARAM = 6,
  parameter int SELW   = 3,
  parameter int TMO_W  = 8
) (
  input logic             clk,
  input logic             clr,
  adpll_cfg_bank_if.slave bus
);

  // Index bound widened by one bit so the comparison never truncates NPARAM.
  localparam logic [SELW:0]    NPARAM_C = (SELW+1)'(NPARAM);
  // Last counter value before the timeout expires; the armed phase lasts
  // exactly 2**TMO_W-1 cycles (counter values 0 .. 2**TMO_W-2).
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(2**TMO_W - 2);
  localparam logic [TMO_W-1:0] TMO_SAT  = {TMO_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_COPY = 2'd2
  } state_t;

  // Even parity of one register: the stored bit makes the total count of ones even.
  function automatic logic even_par(input logic [DW-1:0] d);
    return ^d;
  endfunction

  state_t               state;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 busy_r;
  logic                 done_r;
  logic                 err_sel_r;
  logic                 err_busy_r;
  logic [NPARAM*DW-1:0] shadow;
  logic [NPARAM*DW-1:0] active;

  logic prog_p0, prog_p1, prog_p2;
  logic com_p0, com_p1, com_p2;
  logic prog_edge, com_edge;
  logic sel_ok;
  logic wr_en;
  logic sel_err_now;
  logic busy_err_now;
  logic par_ok;
  logic [DW-1:0] rd_mux;

  // Two-flop synchronisers on the pad strobes plus one flop for edge detection.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prog_p0 <= 1'b0;
      prog_p1 <= 1'b0;
      prog_p2 <= 1'b0;
      com_p0  <= 1'b0;
      com_p1  <= 1'b0;
      com_p2  <= 1'b0;
    end else begin
      prog_p0 <= bus.prog;
      prog_p1 <= prog_p0;
      prog_p2 <= prog_p1;
      com_p0  <= bus.commit;
      com_p1  <= com_p0;
      com_p2  <= com_p1;
    end
  end

  // A held-high strobe yields a single edge; the action lands on the third clk.
  assign prog_edge = prog_p1 & ~prog_p2;
  assign com_edge  = com_p1 & ~com_p2;

  assign sel_ok       = ({1'b0, bus.param_sel} < NPARAM_C);
  // Writes are accepted whenever no commit is pending; a write in the COPY
  // cycle lands in shadow after the copy has taken the previous contents.
  assign wr_en        = prog_edge & sel_ok & (state != S_ARM);
  assign sel_err_now  = prog_edge & ~sel_ok & (state != S_ARM);
  assign busy_err_now = prog_edge & (state == S_ARM);

  // Shadow bank write port.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shadow <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NPARAM; i++) begin
        if (bus.param_sel == SELW'(i)) begin
          shadow[i*DW +: DW] <= bus.pgm_value;
        end
      end
    end
  end

`ifdef ADPLL_CFG_PARITY_EN
  logic [NPARAM-1:0] shadow_par;
  logic              par_err_r;

  // Parity bits are written alongside the shadow data; reset value 0 matches 0 data.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shadow_par <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NPARAM; i++) begin
        if (bus.param_sel == SELW'(i)) begin
          shadow_par[i] <= even_par(bus.pgm_value);
        end
      end
    end
  end

  // Recheck every stored parity; a single mismatch blocks the whole copy.
  always_comb begin
    par_ok = 1'b1;
    for (int i = 0; i < NPARAM; i++) begin
      if (even_par(shadow[i*DW +: DW]) != shadow_par[i]) begin
        par_ok = 1'b0;
      end
    end
  end

  // Sticky parity abort flag; a new abort in the err_clr cycle keeps it set.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      par_err_r <= 1'b0;
    end else begin
      par_err_r <= (par_err_r & ~bus.err_clr) | ((state == S_COPY) & ~par_ok);
    end
  end

  assign bus.par_err = par_err_r;
`else
  assign par_ok      = 1'b1;
  assign bus.par_err = 1'b0;
`endif

  // Commit sequencer: IDLE -> ARM on commit edge, ARM -> COPY on tick/timeout,
  // COPY transfers the whole bank in one edge and returns to IDLE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      active  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (com_edge) begin
            state   <= S_ARM;
            tmo_cnt <= '0;
            busy_r  <= 1'b1;
          end
        end
        S_ARM: begin
          if (bus.sync_tick || (tmo_cnt == TMO_LAST)) begin
            state  <= S_COPY;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else if (tmo_cnt != TMO_SAT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_COPY: begin
          if (par_ok) begin
            active <= shadow;
          end
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky write-error flags; a new error in the err_clr cycle keeps the flag set.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err_sel_r  <= 1'b0;
      err_busy_r <= 1'b0;
    end else begin
      err_sel_r  <= (err_sel_r  & ~bus.err_clr) | sel_err_now;
      err_busy_r <= (err_busy_r & ~bus.err_clr) | busy_err_now;
    end
  end

  // Combinational shadow readback, independent of the commit sequencer.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NPARAM; i++) begin
      if (bus.rd_sel == SELW'(i)) begin
        rd_mux = shadow[i*DW +: DW];
      end
    end
  end

  assign bus.rd_data    = rd_mux;
  assign bus.cfg_active = active;
  assign bus.cfg_busy   = busy_r;
  assign bus.cfg_done   = done_r;
  assign bus.err_sel    = err_sel_r;
  assign bus.err_busy   = err_busy_r;

endmodule

// File: tb/tb_adpll_cfg_bank.sv
// tb_adpll_cfg_bank: directed scenarios plus randomized strobe traffic for
// adpll_cfg_bank, compared every cycle against a behavioural bank model.
module tb_adpll_cfg_bank;
  localparam int DW      = 5;
  localparam int NPARAM  = 6;
  localparam int SELW    = 3;
  localparam int TMO_W   = 8;
  localparam int TMO_CYC = 2**TMO_W - 1;

  logic clk = 1'b0;
  logic clr = 1'b0;
  bit   run = 1'b0;

  adpll_cfg_bank_if #(.DW(DW), .NPARAM(NPARAM), .SELW(SELW)) ifc ();

  adpll_cfg_bank #(.DW(DW), .NPARAM(NPARAM), .SELW(SELW), .TMO_W(TMO_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 armed (busy), 2 copy cycle (done pulse)
  int            m_mode;
  int            m_age;
  logic [DW-1:0] m_sh  [NPARAM];
  logic [DW-1:0] m_act [NPARAM];
  bit            m_esel, m_ebusy;
  bit [3:1]      ph, ch;   // pad level seen 1, 2, 3 clocks ago

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_mode = 0; m_age = 0; m_esel = 0; m_ebusy = 0; ph = '0; ch = '0;
      for (int i = 0; i < NPARAM; i++) begin m_sh[i] = '0; m_act[i] = '0; end
    end else begin
      bit pa, ca, new_sel, new_busy;
      int sel;
      // A pad rise acts on the third clock: high two clocks ago, low three ago.
      pa = ph[2] && !ph[3];
      ca = ch[2] && !ch[3];
      sel = int'(ifc.param_sel);
      new_sel = 0; new_busy = 0;
      if (m_mode == 2)
        for (int i = 0; i < NPARAM; i++) m_act[i] = m_sh[i];
      if (pa) begin
        if (m_mode == 1)       new_busy = 1;
        else if (sel < NPARAM) m_sh[sel] = ifc.pgm_value;
        else                   new_sel = 1;
      end
      case (m_mode)
        0: if (ca) begin m_mode = 1; m_age = 0; end
        1: if (ifc.sync_tick || m_age == TMO_CYC - 1) m_mode = 2; else m_age++;
        default: m_mode = 0;
      endcase
      m_esel  = (m_esel  && !ifc.err_clr) || new_sel;
      m_ebusy = (m_ebusy && !ifc.err_clr) || new_busy;
      ph = {ph[2:1], ifc.prog};
      ch = {ch[2:1], ifc.commit};
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      logic [DW-1:0]        exp_rd;
      logic [NPARAM*DW-1:0] exp_act;
      int idx;
      idx = int'(ifc.rd_sel);
      exp_rd = '0;
      if (idx < NPARAM) exp_rd = m_sh[idx];
      for (int i = 0; i < NPARAM; i++) exp_act[i*DW +: DW] = m_act[i];
      chk("rd_data",    ifc.rd_data,    exp_rd);
      chk("cfg_active", ifc.cfg_active, exp_act);
      chk("cfg_busy",   ifc.cfg_busy,   m_mode == 1);
      chk("cfg_done",   ifc.cfg_done,   m_mode == 2);
      chk("err_sel",    ifc.err_sel,    m_esel);
      chk("err_busy",   ifc.err_busy,   m_ebusy);
      chk("par_err",    ifc.par_err,    1'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_write(input logic [SELW-1:0] sel, input logic [DW-1:0] val);
    ifc.param_sel = sel; ifc.pgm_value = val;
    ifc.prog = 1'b1; step(4);
    ifc.prog = 1'b0; step(2);
  endtask

  task automatic do_commit();
    ifc.commit = 1'b1; step(4);
    ifc.commit = 1'b0; step(1);
  endtask

  task automatic pulse_tick();
    ifc.sync_tick = 1'b1; step(1);
    ifc.sync_tick = 1'b0;
  endtask

  logic [DW-1:0]        vals [NPARAM];
  logic [NPARAM*DW-1:0] exp_vec;
  int                   busy_cnt;

  initial begin
    ifc.prog = 0; ifc.commit = 0; ifc.param_sel = '0; ifc.pgm_value = '0;
    ifc.sync_tick = 0; ifc.err_clr = 0; ifc.rd_sel = '0;
    vals[0] = 5'h0A; vals[1] = 5'h11; vals[2] = 5'h1F;
    vals[3] = 5'h03; vals[4] = 5'h15; vals[5] = 5'h08;
    #1 clr = 1'b1;
    step(2);
    chk("rst_rd_data",  ifc.rd_data,    '0);
    chk("rst_active",   ifc.cfg_active, '0);
    chk("rst_busy",     ifc.cfg_busy,   1'b0);
    chk("rst_done",     ifc.cfg_done,   1'b0);
    chk("rst_err_sel",  ifc.err_sel,    1'b0);
    chk("rst_err_busy", ifc.err_busy,   1'b0);
    clr = 1'b0;
    run = 1'b1;
    step(2);

    // Single write lands on the third clock after the pad rise.
    ifc.rd_sel = 3'd1; ifc.param_sel = 3'd1; ifc.pgm_value = 5'h13; ifc.prog = 1'b1;
    step(2);
    chk("t2_rd_before", ifc.rd_data, 5'h00);
    step(1);
    chk("t2_rd_after",  ifc.rd_data, 5'h13);
    chk("t2_active",    ifc.cfg_active, '0);
    ifc.prog = 1'b0; step(2);

    // Full bank write, commit, tick ten clocks later.
    for (int i = 0; i < NPARAM; i++) do_write(SELW'(i), vals[i]);
    ifc.commit = 1'b1; step(3);
    chk("t3_busy", ifc.cfg_busy, 1'b1);
    ifc.commit = 1'b0; step(9);
    pulse_tick();
    chk("t3_done", ifc.cfg_done, 1'b1);
    chk("t3_busy_copy", ifc.cfg_busy, 1'b0);
    step(1);
    for (int i = 0; i < NPARAM; i++) exp_vec[i*DW +: DW] = vals[i];
    chk("t3_active", ifc.cfg_active, exp_vec);
    chk("t3_done_low", ifc.cfg_done, 1'b0);

    // Commit without tick: busy for the full timeout, then copy.
    do_write(3'd4, 5'h07);
    ifc.commit = 1'b1; step(3);
    ifc.commit = 1'b0;
    busy_cnt = 0;
    while (ifc.cfg_busy && busy_cnt < 400) begin busy_cnt++; step(1); end
    chk("t4_busy_len", busy_cnt, 255);
    chk("t4_done", ifc.cfg_done, 1'b1);
    step(1);
    exp_vec[4*DW +: DW] = 5'h07;
    chk("t4_active", ifc.cfg_active, exp_vec);

    // Bad index, write while armed, then clear.
    ifc.rd_sel = 3'd7;
    do_write(3'd7, 5'h1E);
    chk("t5_err_sel", ifc.err_sel, 1'b1);
    chk("t5_rd_oob", ifc.rd_data, 5'h00);
    do_commit();
    ifc.rd_sel = 3'd2;
    do_write(3'd2, 5'h04);
    chk("t5_err_busy", ifc.err_busy, 1'b1);
    chk("t5_shadow_kept", ifc.rd_data, 5'h1F);
    ifc.err_clr = 1'b1; step(1); ifc.err_clr = 1'b0;
    chk("t5_clr_sel", ifc.err_sel, 1'b0);
    chk("t5_clr_busy", ifc.err_busy, 1'b0);
    pulse_tick(); step(2);

    // Randomized traffic.
    for (int k = 0; k < 250; k++) begin
      int op;
      ifc.rd_sel = SELW'($urandom_range(0, 7));
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: do_write(SELW'($urandom_range(0, 7)), DW'($urandom_range(0, 31)));
        3:       do_commit();
        4, 5:    pulse_tick();
        6:       begin ifc.err_clr = 1'b1; step(1); ifc.err_clr = 1'b0; end
        7: begin
          ifc.param_sel = SELW'($urandom_range(0, 6));
          ifc.pgm_value = DW'($urandom_range(0, 31));
          ifc.prog = 1'b1; ifc.commit = 1'b1; step(4);
          ifc.prog = 1'b0; ifc.commit = 1'b0; step(2);
        end
        default: step($urandom_range(1, 5));
      endcase
    end

    // Reset in the middle of an armed commit.
    pulse_tick(); step(2);
    do_write(3'd0, 5'h1B);
    do_commit();
    step(5);
    ifc.rd_sel = 3'd0;
    #1 clr = 1'b1;
    #1;
    chk("t1_busy",   ifc.cfg_busy,   1'b0);
    chk("t1_active", ifc.cfg_active, '0);
    chk("t1_rd",     ifc.rd_data,    '0);
    chk("t1_esel",   ifc.err_sel,    1'b0);
    step(1);
    clr = 1'b0;
    step(3);
    chk("t1_no_done", ifc.cfg_done, 1'b0);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
